// File: rtl/dplbuf_link_requester.sv
// Per-link requester: gathers 256-bit link beats into 4KB blocks in a local
// buffer, requests the tx arbiter per complete block, streams 128 gapless beats per grant.
module dplbuf_link_requester #(
    parameter int DEPTH_BLKS = 2,
    parameter int BLK_BEATS  = 128,
    parameter int CNT_W      = $clog2(DEPTH_BLKS + 1)
) (
    input  logic             iRST,
    input  logic             iCLK,
    input  logic [255:0]     iWR_DATA,
    input  logic             iWR_V,
    output logic             oREQ,
    input  logic             iGNT,
    output logic [255:0]     oDATA,
    output logic             oDATA_V,
    output logic             oBLK_SENT,
    output logic             oBUF_FULL,
    output logic [CNT_W-1:0] oBLK_CNT,
    output logic             oOVERFLOW,
    output logic             oGNT_ERR
);

    localparam int PTR_W  = $clog2(DEPTH_BLKS);
    localparam int BEAT_W = $clog2(BLK_BEATS);
    localparam int AW     = PTR_W + BEAT_W;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH_BLKS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_BEATS - 1);

    typedef enum logic [1:0] {IDLE_ST, REQ_ST, XFER_ST} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_blk_ptr, rd_blk_ptr;
    logic [BEAT_W-1:0]  wr_beat_ctr, rd_beat_ctr;
    logic [CNT_W-1:0]   blk_cnt, blk_cnt_nxt;
    logic               rd_busy;
    logic               wr_en, blk_done_wr, rd_en, rd_last;
    logic [AW-1:0]      rd_addr;
    logic               req_q, data_v_q, blk_sent_q, full_q, ovf_q, gnt_err_q;
    logic [255:0]       data_q;
    logic [255:0]       mem [DEPTH_BLKS*BLK_BEATS];

    // The partial block always has a slot while fewer than DEPTH blocks are complete.
    assign wr_en       = iWR_V && (blk_cnt != DEPTH_C);
    assign blk_done_wr = wr_en && (wr_beat_ctr == LAST_BEAT);
    assign rd_addr     = {rd_blk_ptr, rd_beat_ctr};

    always_comb begin
        blk_cnt_nxt = blk_cnt;
        case ({blk_done_wr, blk_sent_q})
            2'b10:   blk_cnt_nxt = blk_cnt + CNT_W'(1);
            2'b01:   blk_cnt_nxt = blk_cnt - CNT_W'(1);
            default: blk_cnt_nxt = blk_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_last   = 1'b0;
        case (state)
            IDLE_ST: if (blk_cnt != '0) state_nxt = REQ_ST;
            REQ_ST: begin
                if (iGNT) begin
                    rd_en     = 1'b1;
                    state_nxt = XFER_ST;
                end
            end
            XFER_ST: begin
                if (rd_busy) begin
                    rd_en   = 1'b1;
                    rd_last = (rd_beat_ctr == LAST_BEAT);
                end
                // leave once beat 127 is on the output
                if (blk_sent_q) state_nxt = IDLE_ST;
            end
            default: state_nxt = IDLE_ST;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (wr_en) mem[{wr_blk_ptr, wr_beat_ctr}] <= iWR_DATA;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE_ST;
            wr_blk_ptr  <= '0;
            wr_beat_ctr <= '0;
            rd_blk_ptr  <= '0;
            rd_beat_ctr <= '0;
            rd_busy     <= 1'b0;
            blk_cnt     <= '0;
            req_q       <= 1'b0;
            data_v_q    <= 1'b0;
            blk_sent_q  <= 1'b0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            gnt_err_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            state      <= state_nxt;
            blk_cnt    <= blk_cnt_nxt;
            req_q      <= (state_nxt == REQ_ST);
            full_q     <= (blk_cnt_nxt == DEPTH_C);
            data_v_q   <= rd_en;
            blk_sent_q <= rd_last;
            ovf_q      <= ovf_q | (iWR_V && !wr_en);
            gnt_err_q  <= gnt_err_q | (iGNT && (state != REQ_ST));
            if (wr_en) begin
                wr_beat_ctr <= wr_beat_ctr + BEAT_W'(1);
                if (blk_done_wr) wr_blk_ptr <= wr_blk_ptr + PTR_W'(1);
            end
            // beat counter wraps to 0 after beat 127, ready for the next grant
            if (rd_en) begin
                rd_beat_ctr <= rd_beat_ctr + BEAT_W'(1);
                data_q      <= mem[rd_addr];
            end
            if (state == REQ_ST && iGNT) rd_busy <= 1'b1;
            else if (rd_last)           rd_busy <= 1'b0;
            if (blk_sent_q) rd_blk_ptr <= rd_blk_ptr + PTR_W'(1);
        end
    end

    assign oREQ      = req_q;
    assign oDATA     = data_q;
    assign oDATA_V   = data_v_q;
    assign oBLK_SENT = blk_sent_q;
    assign oBUF_FULL = full_q;
    assign oBLK_CNT  = blk_cnt;
    assign oOVERFLOW = ovf_q;
    assign oGNT_ERR  = gnt_err_q;

endmodule

// File: tb/tb_dplbuf_link_requester.sv
// Directed and randomized checks of block accumulation, request/grant
// streaming, overflow, grant errors and mid-transfer reset.
module tb_dplbuf_link_requester;

    logic         rst, clk, wr_v, gnt;
    logic [255:0] wr_data, data;
    logic         req, data_v, blk_sent, buf_full, overflow, gnt_err;
    logic [1:0]   blk_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int n;
        int cnt;
        bit full;
        bit ovf;
        bit req;
    } vec_t;
    vec_t tbl[4];

    dplbuf_link_requester #(.DEPTH_BLKS(2)) dut (
        .iRST(rst), .iCLK(clk), .iWR_DATA(wr_data), .iWR_V(wr_v),
        .oREQ(req), .iGNT(gnt), .oDATA(data), .oDATA_V(data_v),
        .oBLK_SENT(blk_sent), .oBUF_FULL(buf_full), .oBLK_CNT(blk_cnt),
        .oOVERFLOW(overflow), .oGNT_ERR(gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] dval(input int tag, input int beat);
        logic [31:0] w;
        w = 32'(tag * 65536 + beat);
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_d(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write(input int tag, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            wr_v    = 1'b1;
            wr_data = dval(tag, start + i);
            tick();
        end
        wr_v = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int to;
        to = 0;
        while (!req && to < 3000) begin
            tick();
            to++;
        end
        if (!req) chk(nm, 32'(req), 1);
    endtask

    // Wait for oREQ, grant after gdly cycles, then check all 128 beats.
    task automatic receive(input int tag, input bit do_wr, input int wtag,
                           input int gnt_at, input int gdly);
        int errs;
        wait_req($sformatf("req blk%0d", tag));
        if (!req) return;
        repeat (gdly) tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk($sformatf("req drop blk%0d", tag), 32'(req), 0);
        errs = 0;
        for (int b = 0; b < 128; b++) begin
            if (!data_v || data !== dval(tag, b) || blk_sent !== (b == 127)) errs++;
            gnt = (b == gnt_at);
            if (do_wr) begin
                wr_v    = 1'b1;
                wr_data = dval(wtag, b);
            end
            tick();
        end
        gnt = 1'b0;
        if (do_wr) wr_v = 1'b0;
        chk($sformatf("beats blk%0d", tag), errs, 0);
        chk($sformatf("end blk%0d", tag), 32'(data_v), 0);
    endtask

    initial begin
        int wi, hi;
        tbl[0] = '{n: 127, cnt: 0, full: 1'b0, ovf: 1'b0, req: 1'b0};
        tbl[1] = '{n: 1,   cnt: 1, full: 1'b0, ovf: 1'b0, req: 1'b1};
        tbl[2] = '{n: 128, cnt: 2, full: 1'b1, ovf: 1'b0, req: 1'b1};
        tbl[3] = '{n: 5,   cnt: 2, full: 1'b1, ovf: 1'b1, req: 1'b1};

        rst = 1'b1; wr_v = 1'b0; gnt = 1'b0; wr_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset flags", 32'({req, data_v, blk_sent, buf_full, blk_cnt, overflow, gnt_err}), 0);
        chk_d("reset data", data, '0);

        // single block, beat-index data
        write(0, 0, 128);
        chk("blk_cnt after block", 32'(blk_cnt), 1);
        chk("req one cycle after", 32'(req), 0);
        tick();
        chk("req two cycles after", 32'(req), 1);
        receive(0, 1'b0, 0, -1, 0);
        chk("blk_cnt after send", 32'(blk_cnt), 0);

        // fill, overflow, then refill the freed slot
        wi = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                wr_v    = 1'b1;
                wr_data = dval(10 + wi / 128, wi % 128);
                tick();
                wi++;
            end
            wr_v = 1'b0;
            tick(); tick();
            chk($sformatf("vec%0d cnt", k), 32'(blk_cnt), tbl[k].cnt);
            chk($sformatf("vec%0d full", k), 32'(buf_full), 32'(tbl[k].full));
            chk($sformatf("vec%0d ovf", k), 32'(overflow), 32'(tbl[k].ovf));
            chk($sformatf("vec%0d req", k), 32'(req), 32'(tbl[k].req));
        end
        receive(10, 1'b0, 0, -1, 0);
        chk("cnt after drain", 32'(blk_cnt), 1);
        chk("full after drain", 32'(buf_full), 0);
        chk("ovf sticky", 32'(overflow), 1);
        write(13, 0, 128);
        receive(11, 1'b0, 0, -1, 0);
        receive(13, 1'b0, 0, -1, 0);

        // next block completes on the same cycle as the last sent beat
        write(20, 0, 128);
        receive(20, 1'b1, 21, -1, 0);
        chk("cnt same-cycle inc/dec", 32'(blk_cnt), 1);
        chk("idle gap between blocks", 32'(req), 0);
        receive(21, 1'b0, 0, -1, 0);

        // stray grants
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("gnt_err idle", 32'(gnt_err), 1);
        chk("no data on stray gnt", 32'(data_v), 0);
        write(30, 0, 128);
        receive(30, 1'b0, 0, 64, 0);
        tick(); tick();
        chk("no extra beats", 32'(data_v), 0);
        chk("cnt after stray gnt", 32'(blk_cnt), 0);

        // reset during a transfer
        write(40, 0, 128);
        wait_req("req blk40");
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        repeat (60) tick();
        chk_d("beat 60 before reset", data, dval(40, 60));
        rst = 1'b1;
        #1;
        chk("async reset flags", 32'({req, data_v, blk_sent, buf_full, blk_cnt, overflow, gnt_err}), 0);
        chk_d("async reset data", data, '0);
        tick(); tick();
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req) hi++;
        end
        chk("req low after reset", hi, 0);
        write(41, 0, 127);
        tick(); tick(); tick();
        chk("req low on partial", 32'(req), 0);
        write(41, 127, 1);
        receive(41, 1'b0, 0, -1, 0);

        // randomized writes against randomly delayed grants
        fork
            begin
                int to;
                for (int blk = 0; blk < 20; blk++) begin
                    for (int beat = 0; beat < 128; beat++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        to = 0;
                        while (buf_full && to < 3000) begin
                            tick();
                            to++;
                        end
                        if (buf_full) chk("writer full timeout", 32'(buf_full), 0);
                        wr_v    = 1'b1;
                        wr_data = dval(100 + blk, beat);
                        tick();
                        wr_v = 1'b0;
                    end
                end
            end
            begin
                for (int rb = 0; rb < 20; rb++)
                    receive(100 + rb, 1'b0, 0, -1, int'($urandom_range(0, 50)));
            end
        join
        tick(); tick();
        chk("random drained cnt", 32'(blk_cnt), 0);
        chk("random no overflow", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dplbuf_link_requester.md
Name: dplbuf_link_requester

Overview:
- Per-link requester that sits on the link side of the tx link arbiter, one instance per link port, in bali_pcie_app.
- Accumulates 256-bit link data into 4KB blocks (128 beats each) held in a local block buffer.
- Raises a request to the arbiter whenever a complete block is stored; on grant, streams exactly 128 consecutive beats with no gaps.

Parameters:
DEPTH_BLKS, 2, number of 4KB blocks the local buffer holds (power of 2, >=2)
BLK_BEATS, 128, 256-bit beats per block (fixed 4096/32; not to be overridden)
CNT_W, $clog2(DEPTH_BLKS+1), width of stored-block count

Ports:
iRST  in  1  async reset, active-high
iCLK  in  1  clock
iWR_DATA  in  256  link data beat to store
iWR_V  in  1  write strobe for iWR_DATA
oREQ  out  1  request to arbiter; a complete block is ready
iGNT  in  1  one-cycle grant pulse from arbiter
oDATA  out  256  block beat to arbiter
oDATA_V  out  1  beat valid; 128 consecutive cycles per grant
oBLK_SENT  out  1  one-cycle pulse on the last beat of a block
oBUF_FULL  out  1  no free block slot (status only)
oBLK_CNT  out  CNT_W  complete blocks stored and not yet fully sent
oOVERFLOW  out  1  sticky: write beat dropped because the buffer was full
oGNT_ERR  out  1  sticky: iGNT received while not in REQ_ST

Behaviour:
- All signals clock off iCLK. iRST is asynchronous, active-high. All outputs reset to 0; pointers, counters and FSM clear to IDLE_ST.
- Storage: simple dual-port RAM, DEPTH_BLKS*128 x 256, 1-cycle registered read.
- Write address = {wr_blk_ptr, wr_beat_ctr[6:0]}.
- Write side:
  - iWR_V with a free slot (blk_cnt < DEPTH_BLKS, counting the block being written): write the beat, increment wr_beat_ctr.
  - At beat 127: wr_beat_ctr wraps to 0, wr_blk_ptr increments modulo DEPTH_BLKS, and blk_done_wr pulses.
  - iWR_V with no free slot: beat dropped and oOVERFLOW set. The in-progress partial block is not corrupted; the next accepted beat continues at the same wr_beat_ctr.
- blk_cnt:
  - +1 on blk_done_wr.
  - -1 on the last sent beat.
  - Both in the same cycle: unchanged.
  - Never exceeds DEPTH_BLKS or goes below 0.
- oBLK_CNT = blk_cnt. oBUF_FULL is registered and equals (blk_cnt == DEPTH_BLKS).
- FSM states: IDLE_ST, REQ_ST, XFER_ST.
  - IDLE_ST -> REQ_ST when blk_cnt != 0. oREQ is registered and asserts the cycle after entry.
  - REQ_ST holds until iGNT=1. In the grant cycle the FSM issues the RAM read of beat 0 and goes to XFER_ST. oREQ deasserts the cycle after iGNT.
  - XFER_ST issues reads for beats 1..127 on consecutive cycles. oDATA/oDATA_V are valid one cycle after each read, so beat 0 appears the cycle after iGNT and beat 127 appears 128 cycles after iGNT.
  - On the beat-127 output cycle: oBLK_SENT=1, rd_blk_ptr increments modulo DEPTH_BLKS, and blk_cnt decrements.
  - After beat 127 the FSM returns to IDLE_ST. It re-enters REQ_ST the next cycle if blk_cnt != 0 after the decrement, so there is at least 1 idle cycle between blocks.
- oDATA_V is never deasserted mid-block. oDATA holds its last value when oDATA_V=0.
- iGNT while in IDLE_ST or XFER_ST: ignored, oGNT_ERR set (sticky until reset).
- Writes are permitted concurrently with reads. The block being read is never the block being written, because the read slot is not freed until its beat 127 is output.
- A reset mid-transfer aborts the block: oDATA_V drops immediately (async) and buffer contents are discarded.

Test Plan:
1. Write 128 beats (data = beat index) -> oBLK_CNT=1, oREQ high 2 cycles after beat 127 write; pulse iGNT -> oREQ low next cycle; oDATA_V high 128 cycles starting next cycle carrying 0..127; oBLK_SENT on beat 127; oBLK_CNT=0.
2. DEPTH_BLKS=2: write 256 beats, then 5 more beats -> oBUF_FULL=1 after block 2, extra beats dropped, oOVERFLOW=1. After one grant, the next written beat is stored at beat index 0 of the freed slot.
3. Write block 2 while block 1 transfers, with a block-2 completion landing on the same cycle as block-1 beat 127 -> oBLK_CNT unchanged (1), oREQ re-asserts, second grant streams block-2 data intact.
4. iGNT pulsed in IDLE_ST and again mid-XFER_ST -> no extra data, transfer continues to 128 beats, oGNT_ERR=1.
5. Assert iRST at beat 60 of a transfer -> oDATA_V=0 immediately, all outputs 0, oREQ stays low until a fresh 128-beat block is written.
6. Randomized writes with grant delays of 0-50 cycles over 20 blocks -> every block received as 128 contiguous beats in write order; oDATA_V never drops within a block.
